matrix_op_sequencer: RTL and testbench

MATRIX_OP_SEQUENCER -- requirements
Module: matrix_op_sequencer

---
 rtl/matrix_op_sequencer_if.sv | 42 ++++
 rtl/matrix_op_sequencer.sv | 141 ++++++++++++++
 tb/tb_matrix_op_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/matrix_op_sequencer_if.sv
// Operand-load, accelerator-control and result signals between matrix_op_sequencer and its environment.
// slave = sequencer side, master = environment side (operand source, accelerator, result sink).
interface matrix_op_sequencer_if #(
  parameter int KERNEL_SIZE   = 3,
  parameter int AXI_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH    = $clog2(KERNEL_SIZE * KERNEL_SIZE * KERNEL_SIZE * KERNEL_SIZE)
);
  localparam int N = KERNEL_SIZE * KERNEL_SIZE;

  logic                       s_valid;
  logic                       s_ready;
  logic [AXI_BUS_WIDTH-1:0]   s_multiplier;
  logic [AXI_BUS_WIDTH-1:0]   s_multiplicand;
  logic                       cfg_relu;
  logic [N*AXI_BUS_WIDTH-1:0] multiplier_input;
  logic [N*AXI_BUS_WIDTH-1:0] multiplicand_input;
  logic [N-1:0]               mStart;
  logic                       lin_mux;
  logic                       direct;
  logic [ADDR_WIDTH-1:0]      AddressSelect;
  logic [AXI_BUS_WIDTH-1:0]   finalAccumulate;
  logic                       finalReady;
  logic                       r_valid;
  logic                       r_ready;
  logic [AXI_BUS_WIDTH-1:0]   r_data;
  logic                       r_err;
  logic [15:0]                op_count;

  modport slave (
    input  s_valid, s_multiplier, s_multiplicand, cfg_relu,
    input  finalAccumulate, finalReady, r_ready,
    output s_ready, multiplier_input, multiplicand_input, mStart, lin_mux,
    output direct, AddressSelect, r_valid, r_data, r_err, op_count
  );

  modport master (
    output s_valid, s_multiplier, s_multiplicand, cfg_relu,
    output finalAccumulate, finalReady, r_ready,
    input  s_ready, multiplier_input, multiplicand_input, mStart, lin_mux,
    input  direct, AddressSelect, r_valid, r_data, r_err, op_count
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Loads N operand pairs, fires the accelerator, waits (with timeout) and holds the result; r_valid at t+3 earliest.
// s_ready only in LOAD; the result is held in HOLD until r_ready, stalling further operand loads.
module matrix_op_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int KERNEL_SIZE   = 3,
  parameter int AXI_BUS_WIDTH = 32,
  parameter int TIMEOUT       = 256,
  parameter int ADDR_WIDTH    = $clog2(KERNEL_SIZE * KERNEL_SIZE * KERNEL_SIZE * KERNEL_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_op_sequencer_if.slave bus
);
  localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int BW = N * AXI_BUS_WIDTH;

  if (DATA_WIDTH > AXI_BUS_WIDTH) begin : g_width_chk
    $error("DATA_WIDTH must fit within an AXI_BUS_WIDTH slot");
  end
  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {LOAD, FIRE, WAIT, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            load_cnt_q, load_cnt_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [BW-1:0]            mult_q, mult_d;
  logic [BW-1:0]            mcand_q, mcand_d;
  logic                     lin_mux_q, lin_mux_d;
  logic                     r_valid_q, r_valid_d;
  logic [AXI_BUS_WIDTH-1:0] r_data_q, r_data_d;
  logic                     r_err_q, r_err_d;
  logic [15:0]              op_count_q, op_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      timer_q    <= '0;
      mult_q     <= '0;
      mcand_q    <= '0;
      lin_mux_q  <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_err_q    <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      timer_q    <= timer_d;
      mult_q     <= mult_d;
      mcand_q    <= mcand_d;
      lin_mux_q  <= lin_mux_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_err_q    <= r_err_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    timer_d    = timer_q;
    mult_d     = mult_q;
    mcand_d    = mcand_q;
    lin_mux_d  = lin_mux_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_err_d    = r_err_q;
    op_count_d = op_count_q;

    case (state_q)
      LOAD: begin
        if (bus.s_valid) begin
          for (int n = 0; n < N; n++) begin
            if (load_cnt_q == CW'(n)) begin
              mult_d[n*AXI_BUS_WIDTH +: AXI_BUS_WIDTH]  = bus.s_multiplier;
              mcand_d[n*AXI_BUS_WIDTH +: AXI_BUS_WIDTH] = bus.s_multiplicand;
            end
          end
          // Result mode is fixed per operation by the slot-0 beat only.
          if (load_cnt_q == '0) begin
            lin_mux_d = ~bus.cfg_relu;
          end
          if (load_cnt_q == CW'(N - 1)) begin
            load_cnt_d = '0;
            state_d    = FIRE;
          end else begin
            load_cnt_d = load_cnt_q + CW'(1);
          end
        end
      end
      FIRE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the timeout cycle still counts as a normal result.
        if (bus.finalReady) begin
          r_data_d  = bus.finalAccumulate;
          r_err_d   = 1'b0;
          r_valid_d = 1'b1;
          state_d   = HOLD;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          r_data_d  = '0;
          r_err_d   = 1'b1;
          r_valid_d = 1'b1;
          state_d   = HOLD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      HOLD: begin
        if (bus.r_ready && r_valid_q) begin
          r_valid_d  = 1'b0;
          op_count_d = op_count_q + 16'd1;
          state_d    = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign bus.s_ready            = (state_q == LOAD);
  assign bus.mStart             = {N{state_q == FIRE}};
  assign bus.multiplier_input   = mult_q;
  assign bus.multiplicand_input = mcand_q;
  assign bus.lin_mux            = lin_mux_q;
  assign bus.direct             = 1'b1;
  assign bus.AddressSelect      = '0;
  assign bus.r_valid            = r_valid_q;
  assign bus.r_data             = r_data_q;
  assign bus.r_err              = r_err_q;
  assign bus.op_count           = op_count_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer: table of operations plus hand-written reset and idle-handshake sequences.
module tb_matrix_op_sequencer;
  localparam int KS = 3;
  localparam int N  = KS * KS;
  localparam int W  = 32;
  localparam int BW = N * W;

  typedef struct {
    logic        relu;
    logic [31:0] base;
    logic [31:0] mcand;
    logic [31:0] accum;
    int          ready_at;   // cycle index after FIRE at which finalReady pulses; -1 = never
    logic        fr_load;    // finalReady held high while loading
    logic        junk;       // s_valid held high during FIRE/WAIT/HOLD
    int          hold;
    int          exp_lat;    // clock edges from the FIRE cycle to r_valid
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_lin;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nerr = 0;
  int   nchk = 0;
  int   nops = 0;
  vec_t vecs[5];

  always #5 clk = ~clk;

  matrix_op_sequencer_if #(.KERNEL_SIZE(KS), .AXI_BUS_WIDTH(W)) bus ();

  matrix_op_sequencer #(.KERNEL_SIZE(KS), .AXI_BUS_WIDTH(W), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_ramp(input logic [31:0] base, input logic [31:0] stp);
    logic [BW-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++) r[n*W +: W] = base + stp * n;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 1'b1);
    chk({tag, "_mstart"}, bus.mStart, '0);
    chk({tag, "_r_valid"}, bus.r_valid, 1'b0);
    chk({tag, "_r_data_err"}, {bus.r_data, bus.r_err}, '0);
    chk({tag, "_op_count"}, bus.op_count, 16'd0);
    chk({tag, "_lin_mux"}, bus.lin_mux, 1'b1);
    chk_w({tag, "_mult_buf"}, bus.multiplier_input, '0);
    chk_w({tag, "_mcand_buf"}, bus.multiplicand_input, '0);
  endtask

  task automatic load_beats(input int cnt, input logic [31:0] base, input logic [31:0] mcand,
                            input logic relu, input logic fr);
    for (int n = 0; n < cnt; n++) begin
      bus.s_valid        = 1'b1;
      bus.s_multiplier   = base + n;
      bus.s_multiplicand = mcand;
      bus.cfg_relu       = relu ^ n[0];
      bus.finalReady     = fr;
      step();
    end
    bus.s_valid    = 1'b0;
    bus.finalReady = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input int exp_cnt);
    int            lat;
    logic          got;
    logic [BW-1:0] em;
    logic [BW-1:0] ec;
    em = pack_ramp(v.base, 32'd1);
    ec = pack_ramp(v.mcand, 32'd0);
    load_beats(N, v.base, v.mcand, v.relu, v.fr_load);
    bus.s_valid         = v.junk;
    bus.s_multiplier    = 32'hDEAD_BEEF;
    bus.s_multiplicand  = 32'hCAFE_F00D;
    bus.finalAccumulate = v.accum;
    chk("mstart_fire", bus.mStart, 9'h1FF);
    chk("s_ready_fire", bus.s_ready, 1'b0);
    chk("lin_mux_fire", bus.lin_mux, v.exp_lin);
    chk_w("mult_buf", bus.multiplier_input, em);
    chk_w("mcand_buf", bus.multiplicand_input, ec);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      bus.finalReady = (lat == v.ready_at);
      step();
      lat++;
      if (lat == 1) chk("mstart_one_cycle", bus.mStart, '0);
      got = bus.r_valid;
    end
    bus.finalReady = 1'b0;
    chk("r_valid_latency", lat, v.exp_lat);
    chk("r_data", bus.r_data, v.exp_data);
    chk("r_err", bus.r_err, v.exp_err);
    for (int h = 0; h < v.hold; h++) step();
    chk("hold_r_valid", bus.r_valid, 1'b1);
    chk("hold_r_data", bus.r_data, v.exp_data);
    chk("hold_s_ready", bus.s_ready, 1'b0);
    chk_w("mult_buf_hold", bus.multiplier_input, em);
    chk("lin_mux_hold", bus.lin_mux, v.exp_lin);
    bus.s_valid = 1'b0;
    bus.r_ready = 1'b1;
    step();
    bus.r_ready = 1'b0;
    chk("r_valid_clear", bus.r_valid, 1'b0);
    chk("op_count", bus.op_count, exp_cnt);
  endtask

  initial begin
    vec_t post;

    //         relu  base    mcand  accum          rdy fr_ld junk hold lat  data           err  lin
    vecs[0] = '{1'b0, 32'd1,   32'd2, 32'd90,         3, 1'b0, 1'b0, 3,  4, 32'd90,         1'b0, 1'b1};
    vecs[1] = '{1'b1, 32'd10,  32'd3, 32'hFFFF_FFFB,  1, 1'b0, 1'b1, 20, 2, 32'hFFFF_FFFB,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'd100, 32'd7, 32'd1234,      -1, 1'b1, 1'b0, 2,  9, 32'd0,          1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'd5,   32'd1, 32'd77,         8, 1'b0, 1'b0, 1,  9, 32'd77,         1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'd20,  32'd4, 32'd55,         0, 1'b0, 1'b0, 1,  9, 32'd0,          1'b1, 1'b1};
    post    = '{1'b0, 32'h30,  32'd9, 32'h1234,       2, 1'b0, 1'b0, 1,  3, 32'h1234,       1'b0, 1'b1};

    bus.s_valid         = 1'b0;
    bus.s_multiplier    = '0;
    bus.s_multiplicand  = '0;
    bus.cfg_relu        = 1'b0;
    bus.finalAccumulate = '0;
    bus.finalReady      = 1'b0;
    bus.r_ready         = 1'b0;

    step();
    step();
    check_reset_state("reset");
    chk("direct", bus.direct, 1'b1);
    chk("address_select", bus.AddressSelect, '0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      nops++;
      run_op(vecs[i], nops);
    end

    // Reset in the middle of a load discards the partial operation.
    load_beats(4, 32'hA0, 32'd5, 1'b1, 1'b0);
    chk("lin_mux_partial", bus.lin_mux, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_state("midload_rst");
    step();
    rst = 1'b0;
    step();
    run_op(post, 1);

    // r_ready while no result is pending must not count an operation.
    bus.r_ready = 1'b1;
    step();
    step();
    bus.r_ready = 1'b0;
    chk("idle_r_ready_count", bus.op_count, 16'd1);
    chk("idle_r_ready_valid", bus.r_valid, 1'b0);
    chk("idle_s_ready", bus.s_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
